// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings and the sequential-multiplier state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // ALU operation select, shared by the ALU decoder and every ALU client.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bundle of the shift-add multiplier plus its shared-ALU link.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while the multiplier is busy.
// slave  : multiplier side (takes start/op_a/op_b/alu_out, drives the rest).
// master : requester + ALU side (mirror image).
interface alu_mul_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [2:0]            alu_ctrl;
    logic [DATA_WIDTH-1:0] alu_out;

    modport slave (
        input  start, op_a, op_b, alu_out,
        output busy, done, result, alu_op1, alu_op2, alu_ctrl
    );

    modport master (
        output start, op_a, op_b, alu_out,
        input  busy, done, result, alu_op1, alu_op2, alu_ctrl
    );
endinterface

// File: rtl/alu.sv
// Combinational shared ALU decoding the alu_pkg control encodings.
// Latency: 0 cycles, out follows op1/op2/ctrl in the same cycle.
// Backpressure: none.
// Ports: op1, op2 operands; ctrl operation select; out result.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [2:0]            ctrl,
    output logic [DATA_WIDTH-1:0] out
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = op2[SW-1:0];

    always_comb begin
        out = '0;
        case (ctrl)
            ALU_ADD: out = op1 + op2;
            ALU_SUB: out = op1 - op2;
            ALU_SLL: out = op1 << shamt;
            ALU_XOR: out = op1 ^ op2;
            ALU_SRL: out = op1 >> shamt;
            ALU_OR:  out = op1 | op2;
            ALU_AND: out = op1 & op2;
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier borrowing an external ALU for its adds; low DATA_WIDTH bits of op_a*op_b.
// Latency: done in cycle T+1+k after start at edge T, k = index of top set bit of op_b + 1 (k=1 for op_b=0).
// Backpressure: start honoured only in IDLE; ignored while busy (RUN and DONE).
// Ports: clk, rst (sync, active high); bus = slave side of alu_mul_seq_if.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);
    localparam int                CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DATA_WIDTH - 1);

    mul_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, mcand_q, mplier_q, result_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] acc_nxt;
    logic                  last_step;

    // The ALU is hardwired to acc + mcand; we only decide whether to keep its sum.
    assign acc_nxt   = mplier_q[0] ? bus.alu_out : acc_q;
    // Stop early once no multiplier bits remain, so short op_b finishes fast.
    assign last_step = ((mplier_q >> 1) == '0) || (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q    <= '0;
                        mcand_q  <= bus.op_a;
                        mplier_q <= bus.op_b;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Capture on the way into DONE so result is already valid with done.
                    if (last_step) result_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.alu_op1  = acc_q;
    assign bus.alu_op2  = mcand_q;
    assign bus.alu_ctrl = ALU_ADD;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench: alu_mul_seq wired to the shared ALU, compared with a plain arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_mul_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq_if #(.DATA_WIDTH(W)) bus ();

    alu #(.DATA_WIDTH(W)) u_alu (
        .op1  (bus.alu_op1),
        .op2  (bus.alu_op2),
        .ctrl (bus.alu_ctrl),
        .out  (bus.alu_out)
    );

    alu_mul_seq #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The multiplier must only ever ask the ALU to add.
    always @(negedge clk) chk("alu_ctrl", {61'd0, bus.alu_ctrl}, 64'd0);

    function automatic int model_k(input logic [W-1:0] b);
        int k = 1;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[W-1:0];
    endfunction

    // One operation: start sampled at edge T; cycle n is the cycle after edge T+n-1.
    // With disturb set, operands and start are scrambled while busy (incl. the DONE cycle).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        int          k;
        logic [W-1:0] r;
        k = model_k(b);
        r = model_res(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= k + 3; n++) begin
            @(negedge clk);
            chk("busy", {63'd0, bus.busy}, {63'd0, (n <= k + 1)});
            chk("done", {63'd0, bus.done}, {63'd0, (n == k + 1)});
            if (n >= k + 1) chk("result", {32'd0, bus.result}, {32'd0, r});
            if (disturb && n <= k + 1) begin
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
                bus.start = 1'($urandom_range(0, 1));
                if (n == k + 1) bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    logic [W-1:0] ra, rb;

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_op1", {32'd0, bus.alu_op1}, 64'd0);
        chk("rst_op2", {32'd0, bus.alu_op2}, 64'd0);
        rst = 1'b0;

        run_op(32'd6, 32'd7, 1'b0);
        run_op(32'h12345678, 32'd0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(32'd3, 32'h80000000, 1'b1);

        // Reset mid-RUN: start at edge T, rst sampled at edge T+3.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'd5;
        bus.op_b  = 32'hFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
        chk("mid_rst_result", {32'd0, bus.result}, 64'd0);
        // Reset must win over a simultaneous start.
        bus.start = 1'b1;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd7;
        @(negedge clk);
        chk("rst_vs_start", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_done_after_rst", {63'd0, bus.done}, 64'd0);
        end
        run_op(32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
